// File: rtl/lc3_mem_pkg.sv
// Shared types and limits for the LC3 memory-side responder.
package lc3_mem_pkg;

  localparam int LC3_WORD_W = 16;
  localparam int MAX_WAIT   = 15;

  typedef logic [3:0] wait_cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_state_t;

endpackage

// File: rtl/lc3_mem_chan.sv
// One memory channel: storage array, IDLE/WAIT/DONE handshake FSM with a
// programmable wait counter, and a backdoor write port.
module lc3_mem_chan
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 0,
  parameter bit WRITE_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              complete,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);

  if (WAIT_CYC < 0 || WAIT_CYC > MAX_WAIT) begin : g_bad_wait
    $error("lc3_mem_chan: WAIT_CYC must be in 0..15");
  end

  mem_state_t        state;
  wait_cnt_t         cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_rd;
  logic [DATA_W-1:0] lat_din;
  logic              do_access;
  logic              do_write;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  assign do_access = (state == WAIT) && (cnt == '0);
  assign do_write  = WRITE_EN && do_access && !lat_rd && reset;

  // A request still high on the edge that ends DONE is treated as the next
  // transaction, so back-to-back accesses run every WAIT_CYC+2 cycles.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      complete <= 1'b0;
      dout     <= '0;
    end else begin
      complete <= 1'b0;
      if ((state == IDLE || state == DONE) && req) begin
        state    <= WAIT;
        cnt      <= wait_cnt_t'(WAIT_CYC);
        lat_addr <= addr;
        lat_rd   <= rd || !WRITE_EN;
        lat_din  <= din;
      end else if (state == DONE) begin
        state <= IDLE;
      end else if (state == WAIT) begin
        if (cnt != '0) begin
          cnt <= cnt - wait_cnt_t'(1);
        end else begin
          if (lat_rd) dout <= mem[lat_addr];
          state    <= DONE;
          complete <= 1'b1;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

  // Backdoor write comes last so it overrides a channel write to the same word.
  always_ff @(posedge clock) begin
    if (do_write) mem[lat_addr] <= lat_din;
    if (load_en)  mem[load_addr] <= load_data;
  end

endmodule

// File: rtl/lc3_mem_port.sv
// Memory-side responder for the LC3 pipeline: an instruction channel and a
// data channel, each with its own array and wait states.
module lc3_mem_port
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int IADDR_W    = 8,
  parameter int DADDR_W    = 8,
  parameter int INSTR_WAIT = 0,
  parameter int DATA_WAIT  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instrmem_rd,
  input  logic [LC3_WORD_W-1:0] pc,
  output logic [DATA_W-1:0]     Instr_dout,
  output logic                  complete_instr,
  input  logic                  data_req,
  input  logic                  Data_rd,
  input  logic [LC3_WORD_W-1:0] Data_addr,
  input  logic [DATA_W-1:0]     Data_din,
  output logic [DATA_W-1:0]     Data_dout,
  output logic                  complete_data,
  input  logic                  load_en,
  input  logic                  load_sel,
  input  logic [LC3_WORD_W-1:0] load_addr,
  input  logic [DATA_W-1:0]     load_data
);

  // Upper address bits are dropped on purpose: addresses wrap modulo depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pc, Data_addr, load_addr};

  lc3_mem_chan #(
    .ADDR_W   (IADDR_W),
    .DATA_W   (DATA_W),
    .WAIT_CYC (INSTR_WAIT),
    .WRITE_EN (1'b0)
  ) u_instr (
    .clock     (clock),
    .reset     (reset),
    .req       (instrmem_rd),
    .rd        (1'b1),
    .addr      (pc[IADDR_W-1:0]),
    .din       ('0),
    .dout      (Instr_dout),
    .complete  (complete_instr),
    .load_en   (load_en && !load_sel),
    .load_addr (load_addr[IADDR_W-1:0]),
    .load_data (load_data)
  );

  lc3_mem_chan #(
    .ADDR_W   (DADDR_W),
    .DATA_W   (DATA_W),
    .WAIT_CYC (DATA_WAIT),
    .WRITE_EN (1'b1)
  ) u_data (
    .clock     (clock),
    .reset     (reset),
    .req       (data_req),
    .rd        (Data_rd),
    .addr      (Data_addr[DADDR_W-1:0]),
    .din       (Data_din),
    .dout      (Data_dout),
    .complete  (complete_data),
    .load_en   (load_en && load_sel),
    .load_addr (load_addr[DADDR_W-1:0]),
    .load_data (load_data)
  );

endmodule

// File: tb/tb_lc3_mem_port.sv
// Directed self-checking bench for lc3_mem_port: a default instance
// (INSTR_WAIT=0, DATA_WAIT=2) and a zero-wait instance sharing the inputs.
module tb_lc3_mem_port;

  localparam int DATA_WAIT = 2;

  logic        clock;
  logic        reset;
  logic        instrmem_rd;
  logic [15:0] pc;
  logic        data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic        load_en;
  logic        load_sel;
  logic [15:0] load_addr;
  logic [15:0] load_data;

  logic [15:0] Instr_dout, Data_dout;
  logic        complete_instr, complete_data;
  logic [15:0] Instr_dout_f, Data_dout_f;
  logic        complete_instr_f, complete_data_f;

  int vectors;
  int miscompares;

  lc3_mem_port dut (
    .clock          (clock),
    .reset          (reset),
    .instrmem_rd    (instrmem_rd),
    .pc             (pc),
    .Instr_dout     (Instr_dout),
    .complete_instr (complete_instr),
    .data_req       (data_req),
    .Data_rd        (Data_rd),
    .Data_addr      (Data_addr),
    .Data_din       (Data_din),
    .Data_dout      (Data_dout),
    .complete_data  (complete_data),
    .load_en        (load_en),
    .load_sel       (load_sel),
    .load_addr      (load_addr),
    .load_data      (load_data)
  );

  lc3_mem_port #(.INSTR_WAIT(0), .DATA_WAIT(0)) dut_fast (
    .clock          (clock),
    .reset          (reset),
    .instrmem_rd    (instrmem_rd),
    .pc             (pc),
    .Instr_dout     (Instr_dout_f),
    .complete_instr (complete_instr_f),
    .data_req       (data_req),
    .Data_rd        (Data_rd),
    .Data_addr      (Data_addr),
    .Data_din       (Data_din),
    .Data_dout      (Data_dout_f),
    .complete_data  (complete_data_f),
    .load_en        (load_en),
    .load_sel       (load_sel),
    .load_addr      (load_addr),
    .load_data      (load_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic rd,
                               input logic [15:0] addr, input logic [15:0] din);
    data_req  = req;
    Data_rd   = rd;
    Data_addr = addr;
    Data_din  = din;
  endtask

  task automatic preload(input logic sel, input logic [15:0] addr,
                         input logic [15:0] data);
    load_en   = 1'b1;
    load_sel  = sel;
    load_addr = addr;
    load_data = data;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  // Issues a data read from IDLE, waits (bounded) for completion, checks
  // latency and data, then lets the channel return to IDLE.
  task automatic dataRead(input string tag, input logic [15:0] addr,
                          input logic [15:0] expected);
    int waited;
    applyStimulus(1'b1, 1'b1, addr, 16'h0000);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!complete_data && waited < 20);
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000);
    checkOutput({tag, "_latency"}, 32'(waited), 32'(DATA_WAIT + 2));
    checkOutput({tag, "_data"}, 32'(Data_dout), 32'(expected));
    @(negedge clock);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    instrmem_rd = 1'b0;
    pc          = 16'h0000;
    load_en     = 1'b0;
    load_sel    = 1'b0;
    load_addr   = 16'h0000;
    load_data   = 16'h0000;
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000);

    repeat (3) @(negedge clock);
    checkOutput("rst_complete_instr", 32'(complete_instr), 32'h0);
    checkOutput("rst_complete_data", 32'(complete_data), 32'h0);
    checkOutput("rst_instr_dout", 32'(Instr_dout), 32'h0);
    checkOutput("rst_data_dout", 32'(Data_dout), 32'h0);
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] instruction fetch with address wrap");
    preload(1'b0, 16'h0005, 16'h1234);
    pc          = 16'h0105;
    instrmem_rd = 1'b1;
    @(negedge clock);
    checkOutput("ifetch_c0_complete", 32'(complete_instr), 32'h0);
    @(negedge clock);
    checkOutput("ifetch_c1_complete", 32'(complete_instr), 32'h1);
    checkOutput("ifetch_c1_data", 32'(Instr_dout), 32'h1234);
    instrmem_rd = 1'b0;
    @(negedge clock);
    checkOutput("ifetch_c2_complete", 32'(complete_instr), 32'h0);
    checkOutput("ifetch_c2_hold", 32'(Instr_dout), 32'h1234);
    @(negedge clock);

    $display("[TB] data write then back-to-back read");
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    for (int c = 0; c <= 7; c++) begin
      @(negedge clock);
      checkOutput($sformatf("data_seq_c%0d", c), 32'(complete_data),
                  32'(c == 3 || c == 7));
      if (c == 3) begin
        checkOutput("write_keeps_dout", 32'(Data_dout), 32'h0);
        applyStimulus(1'b1, 1'b1, 16'h0010, 16'h0000);
      end
      if (c == 7) begin
        checkOutput("read_back", 32'(Data_dout), 32'hBEEF);
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000);
      end
    end
    @(negedge clock);

    $display("[TB] held instruction request and load steering");
    preload(1'b1, 16'h0005, 16'hFFFF);
    pc          = 16'h0205;
    instrmem_rd = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clock);
      checkOutput($sformatf("ihold_c%0d", c), 32'(complete_instr),
                  32'(c == 1 || c == 3));
      if (c == 3) begin
        checkOutput("ihold_data", 32'(Instr_dout), 32'h1234);
        instrmem_rd = 1'b0;
      end
    end

    $display("[TB] reset during data write wait");
    preload(1'b1, 16'h0030, 16'h5555);
    applyStimulus(1'b1, 1'b0, 16'h0030, 16'hDEAD);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    checkOutput("rstw_complete_data", 32'(complete_data), 32'h0);
    checkOutput("rstw_data_dout", 32'(Data_dout), 32'h0);
    checkOutput("rstw_instr_dout", 32'(Instr_dout), 32'h0);
    checkOutput("rstw_complete_instr", 32'(complete_instr), 32'h0);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clock);
      checkOutput($sformatf("rstw_quiet_c%0d", c), 32'(complete_data), 32'h0);
    end
    dataRead("rstw_old_word", 16'h0030, 16'h5555);

    $display("[TB] backdoor load against channel write");
    applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0002);
    repeat (3) @(negedge clock);
    load_en   = 1'b1;
    load_sel  = 1'b1;
    load_addr = 16'h0020;
    load_data = 16'h0001;
    @(negedge clock);
    load_en = 1'b0;
    checkOutput("collide_complete", 32'(complete_data), 32'h1);
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000);
    @(negedge clock);
    dataRead("load_wins", 16'h0020, 16'h0001);

    applyStimulus(1'b1, 1'b1, 16'h0020, 16'h0000);
    repeat (3) @(negedge clock);
    load_en   = 1'b1;
    load_sel  = 1'b1;
    load_addr = 16'h0020;
    load_data = 16'h7777;
    @(negedge clock);
    load_en = 1'b0;
    checkOutput("rdcol_complete", 32'(complete_data), 32'h1);
    checkOutput("rdcol_old_word", 32'(Data_dout), 32'h0001);
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000);
    @(negedge clock);
    dataRead("rdcol_new_word", 16'h0020, 16'h7777);

    $display("[TB] concurrent instruction and data requests");
    preload(1'b0, 16'h0040, 16'hAAAA);
    preload(1'b1, 16'h0041, 16'h5A5A);
    pc          = 16'h0040;
    instrmem_rd = 1'b1;
    applyStimulus(1'b1, 1'b1, 16'h0041, 16'h0000);
    for (int c = 0; c <= 4; c++) begin
      @(negedge clock);
      checkOutput($sformatf("conc_fast_ci_c%0d", c), 32'(complete_instr_f), 32'(c == 1));
      checkOutput($sformatf("conc_fast_cd_c%0d", c), 32'(complete_data_f), 32'(c == 1));
      checkOutput($sformatf("conc_main_cd_c%0d", c), 32'(complete_data), 32'(c == 3));
      if (c == 1) begin
        checkOutput("conc_fast_instr", 32'(Instr_dout_f), 32'hAAAA);
        checkOutput("conc_fast_data", 32'(Data_dout_f), 32'h5A5A);
        checkOutput("conc_main_ci", 32'(complete_instr), 32'h1);
        checkOutput("conc_main_instr", 32'(Instr_dout), 32'hAAAA);
        instrmem_rd = 1'b0;
        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000);
      end
      if (c == 3) begin
        checkOutput("dropped_req_completes", 32'(Data_dout), 32'h5A5A);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
